// File: rtl/ddr_rx_pkg.sv
// ddr_rx_pkg: shared types and constants for the DDR receive deserializer.
//   ddr_rx_state_e      : alignment FSM state (HUNT / LOCKED)
//   ddr_rx_phase_t      : which bit phase the word boundary falls on
//                         (0 = word ends on a fall bit, 1 = ends on a rise bit)
//   DDR_RX_SYNC_DEFAULT : default alignment word, MSB first on the wire
package ddr_rx_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ddr_rx_state_e;

  typedef logic ddr_rx_phase_t;

  localparam logic [7:0] DDR_RX_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/ddr_rx_fifo.sv
// ddr_rx_fifo: generic synchronous FIFO, synchronous active-high reset.
// Ports:
//   clk, srst_i        clock, synchronous active-high reset (clears storage)
//   push_i, data_i     write request and data
//   pop_i              read request; ignored while empty
//   data_o             head entry (combinational read of the head slot)
//   full_o, empty_o    occupancy flags
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is silently ignored (the caller decides what a drop means).
module ddr_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr_rx_deser.sv
// ddr_rx_deser: assembles rise/fall captured bit pairs into WIDTH-bit words,
// hunts for SYNC_PATTERN at either bit phase, and buffers words in a FIFO.
// Ports:
//   clk, srst_i              clock, synchronous active-high reset
//   en_i                     rise_bit_i/fall_bit_i hold a valid pair
//   rise_bit_i, fall_bit_i   older / newer bit of the pair
//   align_req_i              drop alignment and re-hunt
//   word_o, word_valid_o     FIFO head word and not-empty flag
//   word_ready_i             consumer accepts word_o
//   locked_o                 FSM is LOCKED
//   overflow_o, clear_ovf_i  sticky word-drop flag and its clear
//   state_o                  FSM state, for observation
// Handshake: a word transfers on every clk edge where word_valid_o and
// word_ready_i are both 1; word_o holds while valid is high and ready low.
// Build option: define DDR_RX_SYNC_STRIP_EN to discard completed words equal
// to SYNC_PATTERN while LOCKED instead of pushing them.
module ddr_rx_deser
  import ddr_rx_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DDR_RX_SYNC_DEFAULT),
  parameter int               FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          srst_i,
  input  logic          en_i,
  input  logic          rise_bit_i,
  input  logic          fall_bit_i,
  input  logic          align_req_i,
  output logic [WIDTH-1:0] word_o,
  output logic          word_valid_o,
  input  logic          word_ready_i,
  output logic          locked_o,
  output logic          overflow_o,
  input  logic          clear_ovf_i,
  output ddr_rx_state_e state_o
);

  localparam int               PAIRS    = WIDTH / 2;
  localparam int               CW       = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(PAIRS - 1);

  ddr_rx_state_e state_q;
  ddr_rx_phase_t phase_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH:0] hist_q;
  logic [WIDTH:0] hist_next;
  logic [WIDTH-1:0] cand0;
  logic [WIDTH-1:0] cand1;
  logic [WIDTH-1:0] word_sel;
  logic          word_done;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  // One extra history bit lets the odd phase (word ending on a rise bit)
  // be read out as hist[WIDTH:1] after the newest pair is shifted in.
  always_comb begin
    hist_next = hist_q;
    if (en_i) hist_next = {hist_q[WIDTH-2:0], rise_bit_i, fall_bit_i};
    cand0    = hist_next[WIDTH-1:0];
    cand1    = hist_next[WIDTH:1];
    word_sel = phase_q ? cand1 : cand0;
  end

  // align_req_i beats a coincident word completion.
  assign word_done = (state_q == LOCKED) && en_i && (cnt_q == CNT_LAST) && !align_req_i;

`ifdef DDR_RX_SYNC_STRIP_EN
  assign push = word_done && (word_sel != SYNC_PATTERN);
`else
  assign push = word_done;
`endif

  assign pop  = word_valid_o && word_ready_i;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (srst_i) begin
      state_q    <= HUNT;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      hist_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      hist_q <= hist_next;
      if (align_req_i) begin
        state_q <= HUNT;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          HUNT: begin
            // Phase 0 is tested first so it wins when both phases match.
            if (en_i && (cand0 == SYNC_PATTERN)) begin
              phase_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= LOCKED;
            end else if (en_i && (cand1 == SYNC_PATTERN)) begin
              phase_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= LOCKED;
            end
          end
          LOCKED: begin
            if (en_i) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          end
          default: state_q <= HUNT;
        endcase
      end
      // Setting has priority over clearing.
      if (drop) overflow_o <= 1'b1;
      else if (clear_ovf_i) overflow_o <= 1'b0;
    end
  end

  assign locked_o     = (state_q == LOCKED);
  assign state_o      = state_q;
  assign word_valid_o = !fifo_empty;

  ddr_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst_i  (srst_i),
    .push_i  (push),
    .data_i  (word_sel),
    .pop_i   (pop),
    .data_o  (word_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ddr_rx_deser.sv
// Bench for ddr_rx_deser (WIDTH=8, SYNC=A5, FIFO_DEPTH=4). The reference
// model keeps the whole received bit stream and finds words by indexing it.
module tb_ddr_rx_deser;
  import ddr_rx_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam logic [W-1:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic srst_i = 1'b0;
  logic en_i = 1'b0;
  logic rise_bit_i = 1'b0;
  logic fall_bit_i = 1'b0;
  logic align_req_i = 1'b0;
  logic [W-1:0] word_o;
  logic word_valid_o;
  logic word_ready_i = 1'b0;
  logic locked_o;
  logic overflow_o;
  logic clear_ovf_i = 1'b0;
  ddr_rx_state_e state_o;

  ddr_rx_deser #(.WIDTH(W), .SYNC_PATTERN(SYNC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .srst_i(srst_i), .en_i(en_i), .rise_bit_i(rise_bit_i),
    .fall_bit_i(fall_bit_i), .align_req_i(align_req_i), .word_o(word_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .locked_o(locked_o), .overflow_o(overflow_o), .clear_ovf_i(clear_ovf_i),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];   // model FIFO contents
  logic [W-1:0] got_q[$];   // words the DUT handed over
  bit   bq[$];              // every bit received since reset
  bit   m_locked;
  int   m_phase;
  int   m_lock_n;
  bit   m_ovf;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_at(input int end_idx);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[W-1-i] = bq[end_idx-W+1+i];
    return w;
  endfunction

  task automatic model_reset();
    bq.delete();
    for (int i = 0; i < W + 2; i++) bq.push_back(1'b0);
    exp_q.delete();
    m_locked = 0; m_phase = 0; m_lock_n = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit en, input bit r, input bit f, input bit al,
                            input bit rdy, input bit clr);
    bit pop, full, done, set_ovf;
    int n;
    logic [W-1:0] w;
    pop = rdy && (exp_q.size() > 0);
    full = (exp_q.size() == D);
    done = 0; set_ovf = 0; w = '0;
    if (en) begin bq.push_back(r); bq.push_back(f); end
    n = bq.size();
    if (al) m_locked = 0;
    else if (!m_locked) begin
      if (en && word_at(n-1) == SYNC) begin m_locked = 1; m_phase = 0; m_lock_n = n; end
      else if (en && word_at(n-2) == SYNC) begin m_locked = 1; m_phase = 1; m_lock_n = n; end
    end else if (en && ((n - m_lock_n) % W == 0)) begin
      done = 1;
      w = word_at(n - 1 - m_phase);
    end
`ifdef DDR_RX_SYNC_STRIP_EN
    if (done && w == SYNC) done = 0;
`endif
    if (pop) void'(exp_q.pop_front());
    if (done) begin
      if (full && !pop) set_ovf = 1;
      else exp_q.push_back(w);
    end
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit en, input bit r, input bit f,
                       input bit al, input bit rdy, input bit clr);
    srst_i = rst; en_i = en; rise_bit_i = r; fall_bit_i = f;
    align_req_i = al; word_ready_i = rdy; clear_ovf_i = clr;
    if (!rst && rdy && exp_q.size() > 0) got_q.push_back(word_o);
    @(posedge clk);
    if (rst) model_reset();
    else model_step(en, r, f, al, rdy, clr);
    #1;
    check_eq("locked", {7'b0, locked_o}, {7'b0, m_locked});
    check_eq("valid", {7'b0, word_valid_o}, {7'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) check_eq("word", word_o, exp_q[0]);
    check_eq("ovf", {7'b0, overflow_o}, {7'b0, m_ovf});
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      drive(1, $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
            $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0));
    got_q.delete();
  endtask

  // One word, MSB first; gaps with en_i low when idle_pct > 0.
  task automatic send_word(input logic [W-1:0] w, input int idle_pct, input bit rdy,
                           input bit clr_last);
    for (int p = 0; p < W / 2; p++) begin
      while ($urandom_range(99, 0) < idle_pct)
        drive(0, 0, $urandom_range(1, 0), $urandom_range(1, 0), 0, rdy, 0);
      drive(0, 1, w[W-1-2*p], w[W-2-2*p], 0, rdy, clr_last && (p == W/2 - 1));
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic check_got(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3, input int n);
    logic [W-1:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    check_eq({tag, "_count"}, W'(got_q.size()), W'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) check_eq(tag, got_q[i], exp[i]);
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit bits[$];
    logic [W-1:0] v;

    // 1. reset and lock on even phase
    do_reset();
    check_eq("rst_word", word_o, 8'h00);
    check_eq("rst_state", {7'b0, state_o}, {7'b0, HUNT});
    send_word(SYNC, 0, 1, 0);
    check_eq("t1_locked", {7'b0, locked_o}, 8'h01);

    // 2. even phase, continuous then gappy enable
    send_word(8'h3C, 0, 1, 0);
    check_eq("t2_lat_valid", {7'b0, word_valid_o}, 8'h01);
    check_eq("t2_lat_word", word_o, 8'h3C);
    send_word(8'h7E, 0, 1, 0);
    idle(3, 1);
    check_got("t2_even", 8'h3C, 8'h7E, 0, 0, 2);
    do_reset();
    send_word(SYNC, 50, 1, 0);
    send_word(8'h3C, 50, 1, 0);
    send_word(8'h7E, 50, 1, 0);
    idle(3, 1);
    check_got("t2_gappy", 8'h3C, 8'h7E, 0, 0, 2);

    // 3. odd phase: leading 0, A5, 3C, trailing pad bit
    do_reset();
    bits.delete();
    bits.push_back(1'b0);
    v = SYNC;   for (int i = W-1; i >= 0; i--) bits.push_back(v[i]);
    v = 8'h3C;  for (int i = W-1; i >= 0; i--) bits.push_back(v[i]);
    bits.push_back(1'b0);
    for (int i = 0; i < bits.size(); i += 2) drive(0, 1, bits[i], bits[i+1], 0, 1, 0);
    idle(2, 1);
    check_eq("t3_locked", {7'b0, locked_o}, 8'h01);
    check_got("t3_odd", 8'h3C, 0, 0, 0, 1);

    // 4. backpressure, overflow, clear, set-beats-clear
    do_reset();
    send_word(SYNC, 0, 0, 0);
    send_word(8'h11, 0, 0, 0); send_word(8'h22, 0, 0, 0);
    send_word(8'h33, 0, 0, 0); send_word(8'h44, 0, 0, 0);
    send_word(8'h55, 0, 0, 0);
    check_eq("t4_ovf", {7'b0, overflow_o}, 8'h01);
    idle(5, 1);
    check_got("t4_drain", 8'h11, 8'h22, 8'h33, 8'h44, 4);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_eq("t4_clr", {7'b0, overflow_o}, 8'h00);
    for (int i = 0; i < 4; i++) send_word(8'h60 + W'(i), 0, 0, 0);
    send_word(8'h99, 0, 0, 1);
    check_eq("t4_set_wins", {7'b0, overflow_o}, 8'h01);
    idle(5, 1);
    check_got("t4_drain2", 8'h60, 8'h61, 8'h62, 8'h63, 4);

    // 5. realign mid-word
    do_reset();
    send_word(SYNC, 0, 0, 0);
    send_word(8'h66, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    check_eq("t5_unlock", {7'b0, locked_o}, 8'h00);
    idle(2, 1);
    send_word(SYNC, 0, 1, 0);
    send_word(8'h11, 0, 1, 0);
    idle(2, 1);
    check_got("t5_realign", 8'h66, 8'h11, 0, 0, 2);

    // 6. sync words inside the locked stream
    do_reset();
    send_word(SYNC, 0, 1, 0);
    send_word(8'h3C, 0, 1, 0); send_word(SYNC, 0, 1, 0); send_word(8'h42, 0, 1, 0);
    idle(3, 1);
`ifdef DDR_RX_SYNC_STRIP_EN
    check_got("t6_strip", 8'h3C, 8'h42, 0, 0, 2);
`else
    check_got("t6_nostrip", 8'h3C, SYNC, 8'h42, 0, 3);
`endif

    // 7. random soak against the model
    do_reset();
    bits.delete();
    while (bits.size() < 3000) begin
      if ($urandom_range(3, 0) == 0) begin
        v = SYNC; for (int i = W-1; i >= 0; i--) bits.push_back(v[i]);
      end else begin
        int n = $urandom_range(W, 1);
        for (int i = 0; i < n; i++) bits.push_back($urandom_range(1, 0));
      end
    end
    while (bits.size() >= 2) begin
      bit en, al, clr, rdy, r, f;
      en  = ($urandom_range(99, 0) < 75);
      al  = ($urandom_range(99, 0) < 1);
      clr = ($urandom_range(99, 0) < 5);
      rdy = ($urandom_range(99, 0) < 60);
      r = 0; f = 0;
      if (en) begin r = bits.pop_front(); f = bits.pop_front(); end
      drive(0, en, r, f, al, rdy, clr);
    end
    idle(6, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
